// File: rtl/cordic_uart_pkg.sv
// cordic_uart_pkg
// Shared types and constants for the CORDIC result UART transmitter.
//   uart_state_t : bit-level serializer states (PARITY only exists when
//                  CORDIC_UART_PARITY_EN is defined)
//   LINE_LEN     : characters per result line
//   ASCII_*      : fixed characters of the line format
//   hex2ascii    : nibble -> uppercase ASCII hex digit
package cordic_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef CORDIC_UART_PARITY_EN
      PARITY,
`endif
      STOP
   } uart_state_t;

   localparam int LINE_LEN = 17;

   localparam logic [7:0] ASCII_R  = 8'h52;
   localparam logic [7:0] ASCII_V  = 8'h56;
   localparam logic [7:0] ASCII_SP = 8'h20;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte
// Byte serializer: start bit, 8 data bits LSB first, optional even parity
// (CORDIC_UART_PARITY_EN), stop bit. Each bit lasts CLKS_PER_BIT cycles.
// A new byte offered during the last stop cycle starts immediately, so
// consecutive bytes have no idle gap.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   byte_valid  : a byte is offered
//   byte_ready  : byte taken at this edge when byte_valid is high
//   byte_data   : byte to send
//   stop_end    : second-to-last cycle of a stop bit (lets the caller
//                 release one cycle before the stop bit completes)
//   tx          : serial output, idles high
module uart_tx_byte
   import cordic_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       byte_valid,
   output logic       byte_ready,
   input  logic [7:0] byte_data,
   output logic       stop_end,
   output logic       tx
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

   uart_state_t   state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
`ifdef CORDIC_UART_PARITY_EN
   logic          par;
`endif

   logic bit_end;
   assign bit_end    = (cnt == CNT_LAST);
   assign byte_ready = (state == IDLE) || (state == STOP && bit_end);
   assign stop_end   = (state == STOP) && (cnt == CNT_PRE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
`ifdef CORDIC_UART_PARITY_EN
         par     <= 1'b0;
`endif
         tx      <= 1'b1;
      end else begin
         if (state == IDLE || bit_end) cnt <= '0;
         else                          cnt <= cnt + CW'(1);

         case (state)
            IDLE: begin
               if (byte_valid) begin
                  shreg <= byte_data;
`ifdef CORDIC_UART_PARITY_EN
                  par   <= ^byte_data;
`endif
                  state <= START;
                  tx    <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  state   <= DATA;
                  bit_idx <= '0;
                  tx      <= shreg[0];
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
`ifdef CORDIC_UART_PARITY_EN
                     state <= PARITY;
                     tx    <= par;
`else
                     state <= STOP;
                     tx    <= 1'b1;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= shreg >> 1;
                     tx      <= shreg[1];
                  end
               end
            end
`ifdef CORDIC_UART_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  state <= STOP;
                  tx    <= 1'b1;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  if (byte_valid) begin
                     // back-to-back byte: straight into the next start bit
                     shreg <= byte_data;
`ifdef CORDIC_UART_PARITY_EN
                     par   <= ^byte_data;
`endif
                     state <= START;
                     tx    <= 1'b0;
                  end else begin
                     state <= IDLE;
                     tx    <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/cordic_result_uart_tx.sv
// cordic_result_uart_tx
// Sends each CORDIC result as one 17-char ASCII line:
//   <'R'|'V'> ' ' <4 hex res_a> ' ' <8 hex res_b> CR LF
// Config macro: CORDIC_UART_PARITY_EN (8E1 when defined, 8N1 otherwise).
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   res_valid/res_ready  : result handshake (ready only while idle)
//   res_mode             : 0 = rotation 'R', 1 = vectoring 'V'
//   res_a [15:0]         : printed as 4 hex chars
//   res_b [31:0]         : printed as 8 hex chars
//   tx                   : UART serial output
//   busy                 : a line is in progress
module cordic_result_uart_tx
   import cordic_uart_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 115_200
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        res_valid,
   output logic        res_ready,
   input  logic        res_mode,
   input  logic [15:0] res_a,
   input  logic [31:0] res_b,
   output logic        tx,
   output logic        busy
);

   localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
   localparam logic [4:0] LAST_CHAR = 5'(LINE_LEN - 1);

   // release happens one cycle before the final stop bit ends, which needs
   // at least two cycles per bit
   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("CLKS_PER_BIT must be at least 2");
   end

   logic        busy_r;
   logic        all_sent;   // last char already handed to the serializer
   logic [4:0]  char_idx;
   logic        cap_mode;
   logic [15:0] cap_a;
   logic [31:0] cap_b;

   logic        byte_valid, byte_ready, stop_end;
   logic [7:0]  ch_data;

   assign res_ready  = ~busy_r;
   assign busy       = busy_r;
   assign byte_valid = busy_r & ~all_sent;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r   <= 1'b0;
         all_sent <= 1'b0;
         char_idx <= '0;
         cap_mode <= 1'b0;
         cap_a    <= '0;
         cap_b    <= '0;
      end else if (!busy_r) begin
         char_idx <= '0;
         all_sent <= 1'b0;
         if (res_valid) begin
            busy_r   <= 1'b1;
            cap_mode <= res_mode;
            cap_a    <= res_a;
            cap_b    <= res_b;
         end
      end else begin
         if (byte_valid && byte_ready) begin
            if (char_idx == LAST_CHAR) all_sent <= 1'b1;
            else                       char_idx <= char_idx + 5'd1;
         end
         // idle again one cycle early so the next accept lands exactly
         // when the final stop bit completes
         if (all_sent && stop_end) begin
            busy_r   <= 1'b0;
            all_sent <= 1'b0;
            char_idx <= '0;
         end
      end
   end

   // line formatter
   always_comb begin
      ch_data = ASCII_SP;
      case (char_idx)
         5'd0:    ch_data = cap_mode ? ASCII_V : ASCII_R;
         5'd2:    ch_data = hex2ascii(cap_a[15:12]);
         5'd3:    ch_data = hex2ascii(cap_a[11:8]);
         5'd4:    ch_data = hex2ascii(cap_a[7:4]);
         5'd5:    ch_data = hex2ascii(cap_a[3:0]);
         5'd7:    ch_data = hex2ascii(cap_b[31:28]);
         5'd8:    ch_data = hex2ascii(cap_b[27:24]);
         5'd9:    ch_data = hex2ascii(cap_b[23:20]);
         5'd10:   ch_data = hex2ascii(cap_b[19:16]);
         5'd11:   ch_data = hex2ascii(cap_b[15:12]);
         5'd12:   ch_data = hex2ascii(cap_b[11:8]);
         5'd13:   ch_data = hex2ascii(cap_b[7:4]);
         5'd14:   ch_data = hex2ascii(cap_b[3:0]);
         5'd15:   ch_data = ASCII_CR;
         5'd16:   ch_data = ASCII_LF;
         default: ch_data = ASCII_SP;
      endcase
   end

   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
      .clk        (clk),
      .rst_n      (rst_n),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .byte_data  (ch_data),
      .stop_end   (stop_end),
      .tx         (tx)
   );

endmodule

// File: tb/tb_cordic_result_uart_tx.sv
module tb_cordic_result_uart_tx;

   localparam int C = 4;
`ifdef CORDIC_UART_PARITY_EN
   localparam int BITS = 11;
`else
   localparam int BITS = 10;
`endif
   localparam int F = 17 * BITS * C;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        res_valid = 1'b0;
   logic        res_mode = 1'b0;
   logic [15:0] res_a = '0;
   logic [31:0] res_b = '0;
   logic        res_ready, tx, busy;

   int checks = 0;
   int errors = 0;
   int lines_rx = 0;
   int cyc = 0;
   bit mon_en = 1'b1;
   logic [7:0] exp_q[$];

   cordic_result_uart_tx #(.CLK_HZ(1_000_000), .BAUD(250_000)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_mode  (res_mode),
      .res_a     (res_a),
      .res_b     (res_b),
      .tx        (tx),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] h2a(input logic [3:0] n);
      return (n <= 4'd9) ? (8'd48 + 8'(n)) : (8'd65 + 8'(n) - 8'd10);
   endfunction

   task automatic push_line(input logic m, input logic [15:0] a, input logic [31:0] b);
      exp_q.push_back(m ? 8'h56 : 8'h52);
      exp_q.push_back(8'h20);
      for (int i = 3; i >= 0; i--) exp_q.push_back(h2a(a[i*4 +: 4]));
      exp_q.push_back(8'h20);
      for (int i = 7; i >= 0; i--) exp_q.push_back(h2a(b[i*4 +: 4]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (res_ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) chk("ready_timeout", n, 0);
   endtask

   // returns at #1 after the accept edge
   task automatic send(input logic m, input logic [15:0] a, input logic [31:0] b);
      @(negedge clk);
      wait_ready();
      res_valid = 1'b1;
      res_mode  = m;
      res_a     = a;
      res_b     = b;
      push_line(m, a, b);
      @(posedge clk);
      #1;
      res_valid = 1'b0;
      chk("acc_ready", res_ready, 0);
      chk("acc_busy", busy, 1);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      @(negedge clk);
      while (busy === 1'b1 && n < 3000) begin
         n++;
         @(negedge clk);
      end
      if (n >= 3000) chk("idle_timeout", n, 0);
   endtask

   // UART receiver: samples mid-bit on negedges and pops the scoreboard
   initial begin : mon
      logic [7:0] d;
      logic st, sp;
`ifdef CORDIC_UART_PARITY_EN
      logic pb;
`endif
      forever begin
         @(negedge clk);
         if (mon_en && rst_n === 1'b1 && tx === 1'b0) begin
            repeat (2) @(negedge clk);
            st = tx;
            for (int i = 0; i < 8; i++) begin
               repeat (4) @(negedge clk);
               d[i] = tx;
            end
`ifdef CORDIC_UART_PARITY_EN
            repeat (4) @(negedge clk);
            pb = tx;
`endif
            repeat (4) @(negedge clk);
            sp = tx;
            if (mon_en) begin
               chk("start_bit", st, 0);
               chk("stop_bit", sp, 1);
`ifdef CORDIC_UART_PARITY_EN
               chk("parity_bit", pb, ^d);
`endif
               if (exp_q.size() == 0) chk("extra_char", exp_q.size(), 1);
               else begin
                  chk("char", d, exp_q.pop_front());
                  if (d == 8'h0A) lines_rx++;
               end
            end
         end
      end
   end

   initial begin : stim
      int n;
      int l0;
      int t[3];

      // reset state
      #2;
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_ready", res_ready, 1);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;

      // rotation line, start bit the cycle after accept
      send(1'b0, 16'h4DBA, 32'h0000_0000);
      chk("t1_tx_at_accept", tx, 1);
      @(posedge clk);
      #1;
      chk("t1_first_start", tx, 0);
      wait_idle(n);
      chk("t1_busy_rest", n, F - 1);
      repeat (5) @(negedge clk);
      chk("t1_q_empty", exp_q.size(), 0);
      chk("t1_lines", lines_rx, 1);

      // vectoring line, busy length
      send(1'b1, 16'h1234, 32'h2000_0000);
      wait_idle(n);
      chk("t2_busy_len", n, F);
      chk("t2_ready_back", res_ready, 1);
      chk("t2_tx_idle", tx, 1);
      repeat (5) @(negedge clk);
      chk("t2_q_empty", exp_q.size(), 0);
      chk("t2_lines", lines_rx, 2);

      // backpressure: valid held high across 3 results
      l0 = lines_rx;
      @(negedge clk);
      res_valid = 1'b1;
      res_mode  = 1'b0;
      res_a     = 16'hA5A5;
      res_b     = 32'h0123_4567;
      push_line(1'b0, 16'hA5A5, 32'h0123_4567);
      for (int k = 0; k < 3; k++) begin
         wait_ready();
         @(posedge clk);
         #1;
         t[k] = cyc;
         chk("bp_accept", res_ready, 0);
         @(negedge clk);
         if (k == 0) begin
            res_mode = 1'b1; res_a = 16'h5A5A; res_b = 32'h89AB_CDEF;
            push_line(1'b1, 16'h5A5A, 32'h89AB_CDEF);
         end else if (k == 1) begin
            res_mode = 1'b0; res_a = 16'h0F1E; res_b = 32'hFFFF_0001;
            push_line(1'b0, 16'h0F1E, 32'hFFFF_0001);
         end else begin
            res_valid = 1'b0;
         end
         repeat (300) @(negedge clk);
         chk("bp_ready_low", res_ready, 0);
      end
      chk("bp_gap01", t[1] - t[0], F + 1);
      chk("bp_gap12", t[2] - t[1], F + 1);
      wait_idle(n);
      repeat (5) @(negedge clk);
      chk("bp_q_empty", exp_q.size(), 0);
      chk("bp_lines", lines_rx - l0, 3);

      // input change after accept has no effect
      send(1'b0, 16'hBEEF, 32'hDEAD_BEEF);
      repeat (5) @(posedge clk);
      #1;
      res_a    = 16'hFFFF;
      res_b    = 32'h0;
      res_mode = 1'b1;
      wait_idle(n);
      repeat (5) @(negedge clk);
      chk("chg_q_empty", exp_q.size(), 0);
      chk("chg_lines", lines_rx, 6);

      // reset mid-line: char 6, frame bit 3
      send(1'b1, 16'hCAFE, 32'h89AB_CDEF);
      repeat (254) @(posedge clk);
      #2;
      chk("rst_pre_busy", busy, 1);
      chk("rst_pre_tx", tx, 0);
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("rst_async_tx", tx, 1);
      chk("rst_async_ready", res_ready, 1);
      chk("rst_async_busy", busy, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      exp_q.delete();
      mon_en = 1'b1;
      l0 = lines_rx;
      send(1'b0, 16'h0F0F, 32'h00C0_FFEE);
      wait_idle(n);
      chk("post_rst_busy_len", n, F);
      repeat (5) @(negedge clk);
      chk("post_rst_q_empty", exp_q.size(), 0);
      chk("post_rst_lines", lines_rx - l0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
